// File: rtl/insn_aligner.sv
// Instruction aligner: buffers 16-bit parcels from fixed-width fetch words and
// presents whole 16/32-bit instructions, handling halfword-misaligned redirects.
module insn_aligner #(
  parameter int FETCH_W     = 32,
  parameter int BUF_PARCELS = 4,
  parameter bit BYTE_SWAP   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               flush_half,
  input  logic               fetch_valid,
  input  logic [FETCH_W-1:0] fetch_data,
  output logic               fetch_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_is_compress,
  output logic               out_illegal
);

  localparam int P  = FETCH_W / 16;
  localparam int PW = $clog2(BUF_PARCELS);
  localparam int CW = PW + 1;

  // Registered state
  logic [15:0]   buf_q [BUF_PARCELS];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          skip_q, skip_d;

  // Incoming parcels (optionally byte-swapped), and the same parcels shifted
  // down by one when the first parcel of the word is to be skipped. Entries
  // beyond the word width are zero so every slot offset indexes in range.
  logic [15:0]   parcel  [P];
  logic [15:0]   shifted [BUF_PARCELS];

  logic [BUF_PARCELS-1:0] wr_en;
  logic [15:0]            wr_data [BUF_PARCELS];

  logic          push, pop, is_32;
  logic [CW-1:0] push_n, pop_n;
  logic [15:0]   h0, h1;

  genvar gi;

  for (gi = 0; gi < P; gi++) begin : g_parcel
    if (BYTE_SWAP) begin : g_swap
      assign parcel[gi] = {fetch_data[gi*16 +: 8], fetch_data[gi*16+8 +: 8]};
    end else begin : g_noswap
      assign parcel[gi] = fetch_data[gi*16 +: 16];
    end
  end

  for (gi = 0; gi < BUF_PARCELS; gi++) begin : g_shift
    if (gi < P - 1) begin : g_mid
      assign shifted[gi] = skip_q ? parcel[gi+1] : parcel[gi];
    end else if (gi == P - 1) begin : g_last
      assign shifted[gi] = parcel[gi];
    end else begin : g_pad
      assign shifted[gi] = 16'h0000;
    end
  end

  // Each buffer slot picks its parcel by its distance from the tail pointer
  for (gi = 0; gi < BUF_PARCELS; gi++) begin : g_slot
    logic [PW-1:0] offset;
    assign offset      = PW'(gi) - tail_q;
    assign wr_en[gi]   = push && ({1'b0, offset} < push_n);
    assign wr_data[gi] = shifted[offset];
  end

  // Head decode and handshakes, all from registered state
  always_comb begin
    h0          = buf_q[head_q];
    h1          = buf_q[head_q + PW'(1)];
    is_32       = (h0[1:0] == 2'b11);
    fetch_ready = (count_q <= CW'(BUF_PARCELS - P));
    out_valid   = (count_q != '0) && (!is_32 || (count_q >= CW'(2)));
    push        = fetch_valid && fetch_ready && !flush;
    push_n      = skip_q ? CW'(P - 1) : CW'(P);
    pop         = out_valid && out_ready;
    pop_n       = is_32 ? CW'(2) : CW'(1);
  end

  // Output formatting; zeroed whenever no complete instruction is present
  always_comb begin
    out_instr       = 32'h0000_0000;
    out_is_compress = 1'b0;
    out_illegal     = 1'b0;
    if (out_valid) begin
      out_instr       = is_32 ? {h1, h0} : {16'h0000, h0};
      out_is_compress = !is_32;
      out_illegal     = (h0 == 16'h0000);
    end
  end

  // Next-state for pointers, occupancy and the skip-first flag
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    skip_d  = skip_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      skip_d  = flush_half;
    end else begin
      if (push) begin
        tail_d = tail_q + push_n[PW-1:0];
        skip_d = 1'b0;
      end
      if (pop) begin
        head_d = head_q + pop_n[PW-1:0];
      end
      count_d = count_q + (push ? push_n : '0) - (pop ? pop_n : '0);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      skip_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      skip_q  <= skip_d;
    end
  end

  // Parcel storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_PARCELS; i++) begin
      if (wr_en[i]) buf_q[i] <= wr_data[i];
    end
  end

endmodule

// File: doc/insn_aligner.md
INSN_ALIGNER -- requirements
Module: insn_aligner

Interface
REQ-001 Parameter FETCH_W, default 32: fetch word width in bits; SHALL be 16, 32 or 64.
REQ-002 Parameter BUF_PARCELS, default 4: depth of the 16-bit parcel buffer; SHALL be a power of two and >= FETCH_W/16 + 1.
REQ-003 Parameter BYTE_SWAP, default 1: 1 = swap the two bytes of each incoming parcel before buffering.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  jump/hazard redirect; discards all buffered parcels.
REQ-007 flush_half  input  1  sampled with flush; 1 = redirect target is halfword-misaligned (PC[1]=1).
REQ-008 fetch_valid  input  1  fetch_data is valid.
REQ-009 fetch_data  input  FETCH_W  fetch word; parcel 0 = bits [15:0], lowest address.
REQ-010 fetch_ready  output  1  block accepts a fetch word this cycle.
REQ-011 out_valid  output  1  out_instr holds a complete instruction.
REQ-012 out_ready  input  1  consumer accepts out_instr (low = stall).
REQ-013 out_instr  output  32  raw instruction; compressed = {16'h0000, parcel}.
REQ-014 out_is_compress  output  1  out_instr is a 16-bit instruction.
REQ-015 out_illegal  output  1  head parcel is 16'h0000.

Function
REQ-016 Define P = FETCH_W/16; the buffer SHALL be a circular FIFO of BUF_PARCELS parcels with head/tail pointers wrapping modulo BUF_PARCELS and a count register of width clog2(BUF_PARCELS)+1.
REQ-017 fetch_ready SHALL be 1 iff (BUF_PARCELS - count) >= P, computed from registered count only (no combinational path from out_ready).
REQ-018 Fetch handshake: fetch_valid && fetch_ready && !flush SHALL enqueue parcels 0..P-1 in ascending order, each byte-swapped when BYTE_SWAP=1.
REQ-019 If skip_first is set, the next accepted fetch word SHALL enqueue only parcels 1..P-1 and clear skip_first; when P=1 the whole word is dropped.
REQ-020 Length decode on head parcel h0: h0[1:0]==2'b11 -> 32-bit, else 16-bit.
REQ-021 out_valid SHALL be 1 when 16-bit and count>=1, or 32-bit and count>=2; otherwise 0.
REQ-022 32-bit: out_instr = {h1, h0}, out_is_compress=0; 16-bit: out_instr = {16'h0, h0}, out_is_compress=1.
REQ-023 out_illegal SHALL be 1 iff out_valid && h0==16'h0000; such a parcel is treated as 16-bit and consumed as one parcel.
REQ-024 out_valid && out_ready SHALL pop 1 parcel (16-bit) or 2 parcels (32-bit).
REQ-025 Simultaneous enqueue and pop in one cycle SHALL be supported; count_next = count + pushed - popped.
REQ-026 Latency: a word accepted at edge N SHALL be visible on out_* in the cycle after edge N (outputs combinational from registered buffer state).
REQ-027 Stall: while out_valid && !out_ready, out_instr, out_is_compress and out_illegal SHALL be held stable.
REQ-028 A 32-bit instruction whose upper half is not yet buffered SHALL keep out_valid=0 without popping its lower half.
REQ-029 flush SHALL have priority over fetch and pop: next cycle count=0, head=tail=0, out_valid=0, skip_first=flush_half; a fetch word offered with flush SHALL be discarded.
REQ-030 Status signals SHALL never be X after reset, including on pointer wrap-around.

Reset
REQ-031 rst_n=0 at an edge SHALL force count=0, head=tail=0, skip_first=0; as a result out_valid=0 and fetch_ready=1, with out_instr=0, out_is_compress=0 and out_illegal=0; this takes priority over flush and all handshakes, including mid-instruction.

Verification
REQ-032 FETCH_W=32, BYTE_SWAP=0, fetch 0x4501_0513 -> one instruction out_instr=0x4501_0513, out_is_compress=0.
REQ-033 Fetch 0x0513_4501 then 0xXXXX_4505 (BYTE_SWAP=0) -> 0x0000_4501 (compressed), then 32-bit 0x4505_0513 spanning words; count=1 afterwards.
REQ-034 out_ready=0 for 3 cycles with buffer full -> fetch_ready=0, out_instr constant; release -> in-order drain, no loss.
REQ-035 flush=1, flush_half=1, then fetch 0x0001_ABCD -> parcel 0xABCD dropped; out 0x0000_0001, out_is_compress=1.
REQ-036 Fetch word 0x0000_0000 -> two outputs, each out_illegal=1 and out_is_compress=1.
REQ-037 FETCH_W=64, BUF_PARCELS=8: random 16/32-bit mix over 1000 words vs reference queue model -> exact instruction sequence match.
